distance_presence_ctrl: RTL and testbench
=========================================

Name: distance_presence_ctrl

Overview:
- Downstream consumer of the ultrasonic ranger's 12-bit centimetre result in the multifunctional fan.
- Rejects out-of-range samples and median-of-3 filters the rest.
- Runs a hysteresis/confirmation FSM that produces a clean `present` flag for fan auto-on/off.
- A watchdog flags a sensor fault when measurements stop arriving.

Parameters:
- MAX_VALID_CM, 400, samples of 0 or above this value are invalid.
- NEAR_CM, 30, filtered distance strictly below this counts as a "near" sample.
- FAR_CM, 40, filtered distance strictly above this counts as a "far" sample. Require NEAR_CM < FAR_CM.
- CONFIRM_N, 3, consecutive qualifying filtered samples needed to change presence (1..15).
- TIMEOUT_CYC, 30_000_000, clk cycles without `dist_valid` before a fault (300 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- reset_p  in  1  reset
- enable  in  1  block enable from the fan mode controller
- dist_valid  in  1  one-cycle strobe: new `distance` result available
- distance  in  12  measured distance, cm
- filt_distance  out  12  median-filtered distance, cm
- filt_valid  out  1  one-cycle strobe when `filt_distance` updates
- present  out  1  object/user confirmed near
- sensor_fault  out  1  watchdog or invalid-data fault
- pstate  out  2  presence FSM state (debug)

Behaviour:
- Clock and reset:
  - Reset `reset_p`: asynchronous, active-high. Clock `clk`: all flops on posedge.
  - Reset values: `filt_distance`=0, `filt_valid`=0, `present`=0, `sensor_fault`=0, `pstate`=ABSENT(2'd0). Sample regs, fill count, confirm count and watchdog all 0.
- Sample acceptance (on `dist_valid`):
  - Valid if 1 <= `distance` <= MAX_VALID_CM.
  - Valid sample: shift into s2<=s1, s1<=s0, s0<=distance. Fill count saturates at 3. Bad counter cleared.
  - Invalid sample: filter untouched, bad counter +1. Reaching 3 sets `sensor_fault`.
- Filter output:
  - When a valid sample brings fill to 3 (or fill already 3), `filt_distance` <= median(s0,s1,s2) including the new sample.
  - `filt_valid` pulses the cycle after `dist_valid` (latency 1). No pulse while fill < 3.
  - Median uses unsigned 12-bit compares. Ties return the duplicated value.
- Presence FSM: states ABSENT=0, NEAR_PEND=1, PRESENT=2, FAR_PEND=3. Evaluated only on `filt_valid`; count is the confirm counter.
  - ABSENT: filt<NEAR_CM → count=1 and NEAR_PEND, or PRESENT directly if CONFIRM_N=1.
  - NEAR_PEND: filt<NEAR_CM → count+1; count reaching CONFIRM_N → PRESENT. Otherwise → ABSENT, count=0.
  - PRESENT: filt>FAR_CM → count=1 and FAR_PEND, or ABSENT if CONFIRM_N=1. Values in [NEAR_CM, FAR_CM] hold state.
  - FAR_PEND: filt>FAR_CM → count+1; reaching CONFIRM_N → ABSENT. Otherwise → PRESENT, count=0.
  - `present`=1 in PRESENT and FAR_PEND. It is registered with the state, so latency from `dist_valid` to `present` is 2 cycles.
- Watchdog:
  - Counts clk cycles while `enable`=1. Any `dist_valid` (valid or not) clears it.
  - On reaching TIMEOUT_CYC-1: `sensor_fault`=1, FSM→ABSENT, `present`=0, fill=0, counter saturates.
  - Terminal count and `dist_valid` in the same cycle: `dist_valid` wins, no fault.
- Fault clear: the first valid sample clears `sensor_fault`. The filter then refills from empty, so three valid samples are needed before `filt_valid`.
- `enable`=0:
  - Synchronously clears FSM to ABSENT, `present`, fill, counts, watchdog and `sensor_fault`. Samples are ignored.
  - `filt_distance` holds its last value.
  - Re-enable starts fresh.
- Reset mid-operation: everything returns to reset values immediately. No pending strobes survive.

Decomposition:
- Shared package `presence_pkg`: state encodings (ABSENT/NEAR_PEND/PRESENT/FAR_PEND), 12-bit distance width constant, default thresholds.
- One natural sub-module: `median3_u12`, a purely combinational three-input unsigned median.
- FSM, watchdog and sample registers stay in the top.

Test Plan:
- Three valid samples of 100, 20, 50 → no `filt_valid` after the first two; after the third, `filt_valid` pulses once with `filt_distance`=50; `present`=0.
- Samples of 20,20,20,20,20 (CONFIRM_N=3) → `filt_valid` on samples 3, 4, 5; `pstate` goes 1, 1(count2), 2; `present`=1 two cycles after the 5th `dist_valid`.
- While PRESENT, samples 35,35,35 → stays PRESENT. Then 60,60,60 → FAR_PEND then ABSENT on the 3rd qualifying far sample; `present` drops.
- Samples 0, 500, 4095 consecutively → filter unchanged, no `filt_valid`, `sensor_fault`=1 after the third; next valid 25 clears the fault.
- TIMEOUT_CYC=100, PRESENT, no `dist_valid` for 100 cycles → `sensor_fault`=1, `present`=0, `pstate`=0. Repeat with `dist_valid` on cycle 99 → no fault.
- `enable` low for 1 cycle while PRESENT → `present`=0, `pstate`=0, fault clear; re-enable, and the next two samples produce no `filt_valid`.

Source files
------------

// File: rtl/presence_pkg.sv
// Shared types and defaults for the distance/presence controller.
package presence_pkg;

  localparam int unsigned DIST_W = 12;

  localparam int unsigned DEF_MAX_VALID_CM = 400;
  localparam int unsigned DEF_NEAR_CM      = 30;
  localparam int unsigned DEF_FAR_CM       = 40;
  localparam int unsigned DEF_CONFIRM_N    = 3;
  localparam int unsigned DEF_TIMEOUT_CYC  = 30_000_000;

  // Presence FSM encoding, also exported on the pstate debug port.
  typedef enum logic [1:0] {
    ABSENT    = 2'd0,
    NEAR_PEND = 2'd1,
    PRESENT   = 2'd2,
    FAR_PEND  = 2'd3
  } pstate_t;

endpackage

// File: rtl/distance_presence_ctrl_median3.sv
// Combinational median of three unsigned distances.
module median3_u12
  import presence_pkg::*;
(
  input  logic [DIST_W-1:0] a,
  input  logic [DIST_W-1:0] b,
  input  logic [DIST_W-1:0] c,
  output logic [DIST_W-1:0] m
);

  logic [DIST_W-1:0] lo_ab;
  logic [DIST_W-1:0] hi_ab;
  logic [DIST_W-1:0] min_hi_c;

  // median = max(min(a,b), min(max(a,b), c)); ties resolve to the repeated value
  always_comb begin
    lo_ab    = (a < b) ? a : b;
    hi_ab    = (a < b) ? b : a;
    min_hi_c = (hi_ab < c) ? hi_ab : c;
    m        = (lo_ab > min_hi_c) ? lo_ab : min_hi_c;
  end

endmodule

// File: rtl/distance_presence_ctrl.sv
// Ultrasonic distance consumer: sample validation, median-of-3 filter,
// presence confirmation FSM and a no-data watchdog.
//
// Handshake: dist_valid is a single-cycle strobe with no back-pressure; the
// block always accepts. filt_valid is a single-cycle strobe, one cycle after
// the dist_valid that produced it, with filt_distance stable from then on.
module distance_presence_ctrl
  import presence_pkg::*;
#(
  parameter int unsigned MAX_VALID_CM = DEF_MAX_VALID_CM,
  parameter int unsigned NEAR_CM      = DEF_NEAR_CM,
  parameter int unsigned FAR_CM       = DEF_FAR_CM,
  parameter int unsigned CONFIRM_N    = DEF_CONFIRM_N,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              enable,
  input  logic              dist_valid,
  input  logic [DIST_W-1:0] distance,
  output logic [DIST_W-1:0] filt_distance,
  output logic              filt_valid,
  output logic              present,
  output logic              sensor_fault,
  output logic [1:0]        pstate
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [DIST_W-1:0] MAX_L  = DIST_W'(MAX_VALID_CM);
  localparam logic [DIST_W-1:0] NEAR_L = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] FAR_L  = DIST_W'(FAR_CM);
  localparam logic [3:0]        CONF_L = 4'(CONFIRM_N);

  logic [DIST_W-1:0] s0_q, s1_q, s2_q;
  logic [1:0]        fill_q;
  logic [1:0]        bad_q;
  logic [WD_W-1:0]   wd_q;
  logic [DIST_W-1:0] med;
  logic              sample_ok;
  logic              wd_fire;

  pstate_t    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Median of the incoming sample and the two most recent accepted ones
  median3_u12 u_median (
    .a (distance),
    .b (s0_q),
    .c (s1_q),
    .m (med)
  );

  assign sample_ok = (distance != '0) && (distance <= MAX_L);
  // A strobe on the terminal cycle counts as data arriving in time
  assign wd_fire   = enable && !dist_valid && (wd_q == WD_TERM);

  // Sample history, filter output, bad-sample count, watchdog and fault flag
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      fill_q        <= '0;
      bad_q         <= '0;
      wd_q          <= '0;
      filt_distance <= '0;
      filt_valid    <= 1'b0;
      sensor_fault  <= 1'b0;
    end else if (!enable) begin
      fill_q       <= '0;
      bad_q        <= '0;
      wd_q         <= '0;
      filt_valid   <= 1'b0;
      sensor_fault <= 1'b0;
    end else begin
      filt_valid <= 1'b0;
      if (dist_valid) begin
        wd_q <= '0;
        if (sample_ok) begin
          s2_q         <= s1_q;
          s1_q         <= s0_q;
          s0_q         <= distance;
          bad_q        <= '0;
          sensor_fault <= 1'b0;
          if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
          if (fill_q >= 2'd2) begin
            filt_distance <= med;
            filt_valid    <= 1'b1;
          end
        end else begin
          if (bad_q != 2'd3) bad_q <= bad_q + 2'd1;
          // A faulted sensor's history is discarded; recovery refills from empty
          if (bad_q >= 2'd2) begin
            sensor_fault <= 1'b1;
            fill_q       <= '0;
          end
        end
      end else if (wd_q == WD_TERM) begin
        sensor_fault <= 1'b1;
        fill_q       <= '0;
      end else begin
        wd_q <= wd_q + WD_W'(1);
      end
    end
  end

  // Presence state and confirmation counter registers
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ABSENT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: hysteresis with CONFIRM_N consecutive qualifying filtered samples
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (filt_valid) begin
      case (state_q)
        ABSENT: begin
          if (filt_distance < NEAR_L) begin
            if (CONF_L == 4'd1) begin
              state_d = PRESENT;
              cnt_d   = '0;
            end else begin
              state_d = NEAR_PEND;
              cnt_d   = 4'd1;
            end
          end
        end
        NEAR_PEND: begin
          if (filt_distance < NEAR_L) begin
            if (cnt_q + 4'd1 >= CONF_L) begin
              state_d = PRESENT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ABSENT;
            cnt_d   = '0;
          end
        end
        PRESENT: begin
          if (filt_distance > FAR_L) begin
            if (CONF_L == 4'd1) begin
              state_d = ABSENT;
              cnt_d   = '0;
            end else begin
              state_d = FAR_PEND;
              cnt_d   = 4'd1;
            end
          end
        end
        FAR_PEND: begin
          if (filt_distance > FAR_L) begin
            if (cnt_q + 4'd1 >= CONF_L) begin
              state_d = ABSENT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = PRESENT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ABSENT;
          cnt_d   = '0;
        end
      endcase
    end
    if (!enable || wd_fire) begin
      state_d = ABSENT;
      cnt_d   = '0;
    end
  end

  assign pstate  = state_q;
  assign present = (state_q == PRESENT) || (state_q == FAR_PEND);

endmodule

// File: tb/tb_distance_presence_ctrl.sv
// Directed bench for distance_presence_ctrl (watchdog shortened to 100 cycles).
module tb_distance_presence_ctrl;

  logic        clk;
  logic        reset_p;
  logic        enable;
  logic        dist_valid;
  logic [11:0] distance;
  logic [11:0] filt_distance;
  logic        filt_valid;
  logic        present;
  logic        sensor_fault;
  logic [1:0]  pstate;

  int total;
  int bad;

  distance_presence_ctrl #(
    .MAX_VALID_CM (400),
    .NEAR_CM      (30),
    .FAR_CM       (40),
    .CONFIRM_N    (3),
    .TIMEOUT_CYC  (100)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .enable        (enable),
    .dist_valid    (dist_valid),
    .distance      (distance),
    .filt_distance (filt_distance),
    .filt_valid    (filt_valid),
    .present       (present),
    .sensor_fault  (sensor_fault),
    .pstate        (pstate)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [11:0] d;
    logic        fv;
    logic [11:0] fd;
    logic [1:0]  ps;
    logic        pr;
    logic        flt;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One strobe; outputs captured 1 cycle after (filter) and 2 cycles after (FSM)
  task automatic send(input logic [11:0] d, output logic fv, output logic [11:0] fd,
                      output logic flt, output logic fv2, output logic [1:0] ps,
                      output logic pr);
    dist_valid = 1'b1;
    distance   = d;
    @(posedge clk); #1;
    dist_valid = 1'b0;
    fv  = filt_valid;
    fd  = filt_distance;
    flt = sensor_fault;
    @(posedge clk); #1;
    fv2 = filt_valid;
    ps  = pstate;
    pr  = present;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic        fv, flt, fv2, pr;
    logic [11:0] fd;
    logic [1:0]  ps;
    total = 0;
    bad   = 0;

    vecs[0]  = '{12'd20,   1'b0, 12'd0,  2'd0, 1'b0, 1'b0};
    vecs[1]  = '{12'd20,   1'b0, 12'd0,  2'd0, 1'b0, 1'b0};
    vecs[2]  = '{12'd20,   1'b1, 12'd20, 2'd1, 1'b0, 1'b0};
    vecs[3]  = '{12'd20,   1'b1, 12'd20, 2'd1, 1'b0, 1'b0};
    vecs[4]  = '{12'd20,   1'b1, 12'd20, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{12'd35,   1'b1, 12'd20, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{12'd35,   1'b1, 12'd35, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{12'd35,   1'b1, 12'd35, 2'd2, 1'b1, 1'b0};
    vecs[8]  = '{12'd60,   1'b1, 12'd35, 2'd2, 1'b1, 1'b0};
    vecs[9]  = '{12'd60,   1'b1, 12'd60, 2'd3, 1'b1, 1'b0};
    vecs[10] = '{12'd60,   1'b1, 12'd60, 2'd3, 1'b1, 1'b0};
    vecs[11] = '{12'd60,   1'b1, 12'd60, 2'd0, 1'b0, 1'b0};
    vecs[12] = '{12'd25,   1'b1, 12'd60, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{12'd25,   1'b1, 12'd25, 2'd1, 1'b0, 1'b0};
    vecs[14] = '{12'd45,   1'b1, 12'd25, 2'd1, 1'b0, 1'b0};
    vecs[15] = '{12'd45,   1'b1, 12'd45, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{12'd30,   1'b1, 12'd45, 2'd0, 1'b0, 1'b0};
    vecs[17] = '{12'd30,   1'b1, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[18] = '{12'd30,   1'b1, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[19] = '{12'd400,  1'b1, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[20] = '{12'd401,  1'b0, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[21] = '{12'd0,    1'b0, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[22] = '{12'd4095, 1'b0, 12'd30, 2'd0, 1'b0, 1'b1};
    vecs[23] = '{12'd25,   1'b0, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[24] = '{12'd25,   1'b0, 12'd30, 2'd0, 1'b0, 1'b0};
    vecs[25] = '{12'd25,   1'b1, 12'd25, 2'd1, 1'b0, 1'b0};

    // reset
    reset_p    = 1'b1;
    enable     = 1'b1;
    dist_valid = 1'b0;
    distance   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_p = 1'b0;
    check("rst_filt_distance", 32'(filt_distance), 32'd0);
    check("rst_filt_valid", 32'(filt_valid), 32'd0);
    check("rst_present", 32'(present), 32'd0);
    check("rst_fault", 32'(sensor_fault), 32'd0);
    check("rst_pstate", 32'(pstate), 32'd0);

    // table
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].d, fv, fd, flt, fv2, ps, pr);
      check($sformatf("v%0d_filt_valid", i), 32'(fv), 32'(vecs[i].fv));
      check($sformatf("v%0d_filt_distance", i), 32'(fd), 32'(vecs[i].fd));
      check($sformatf("v%0d_fault", i), 32'(flt), 32'(vecs[i].flt));
      check($sformatf("v%0d_single_pulse", i), 32'(fv2), 32'd0);
      check($sformatf("v%0d_pstate", i), 32'(ps), 32'(vecs[i].ps));
      check($sformatf("v%0d_present", i), 32'(pr), 32'(vecs[i].pr));
    end

    // reach PRESENT, then drop enable for one cycle
    send(12'd25, fv, fd, flt, fv2, ps, pr);
    check("pre_dis_pstate1", 32'(ps), 32'd1);
    send(12'd25, fv, fd, flt, fv2, ps, pr);
    check("pre_dis_present", 32'(pr), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    check("dis_present", 32'(present), 32'd0);
    check("dis_pstate", 32'(pstate), 32'd0);
    check("dis_fault", 32'(sensor_fault), 32'd0);
    check("dis_hold_filt", 32'(filt_distance), 32'd25);

    // fresh refill: 100, 20, 50 -> median 50 only on the third
    send(12'd100, fv, fd, flt, fv2, ps, pr);
    check("refill1_fv", 32'(fv), 32'd0);
    send(12'd20, fv, fd, flt, fv2, ps, pr);
    check("refill2_fv", 32'(fv), 32'd0);
    send(12'd50, fv, fd, flt, fv2, ps, pr);
    check("refill3_fv", 32'(fv), 32'd1);
    check("refill3_fd", 32'(fd), 32'd50);
    check("refill3_present", 32'(pr), 32'd0);

    // back to PRESENT: medians 20,20,20
    for (int i = 0; i < 3; i++) send(12'd20, fv, fd, flt, fv2, ps, pr);
    check("wd_setup_present", 32'(pr), 32'd1);

    // watchdog: strobe arrives exactly on the terminal cycle
    idle(98);
    check("wd_99_idle_fault", 32'(sensor_fault), 32'd0);
    send(12'd20, fv, fd, flt, fv2, ps, pr);
    check("wd_terminal_dv_fault", 32'(flt), 32'd0);
    check("wd_terminal_dv_present", 32'(pr), 32'd1);

    // watchdog: 100 idle cycles trips the fault
    idle(98);
    check("wd_99_idle_fault_b", 32'(sensor_fault), 32'd0);
    check("wd_99_idle_present_b", 32'(present), 32'd1);
    idle(1);
    check("wd_fire_fault", 32'(sensor_fault), 32'd1);
    check("wd_fire_present", 32'(present), 32'd0);
    check("wd_fire_pstate", 32'(pstate), 32'd0);
    idle(5);
    check("wd_fault_holds", 32'(sensor_fault), 32'd1);

    // recovery: first valid sample clears fault, filter empty again
    send(12'd20, fv, fd, flt, fv2, ps, pr);
    check("recover_fault", 32'(flt), 32'd0);
    check("recover_fv", 32'(fv), 32'd0);

    // asynchronous reset mid-operation
    #2;
    reset_p = 1'b1;
    #1;
    check("arst_filt_distance", 32'(filt_distance), 32'd0);
    check("arst_filt_valid", 32'(filt_valid), 32'd0);
    check("arst_pstate", 32'(pstate), 32'd0);
    check("arst_fault", 32'(sensor_fault), 32'd0);
    @(posedge clk); #1;
    reset_p = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
